// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract split into STAGES carry-chained slices with a valid/ready stream.
// Optional overflow flag output is enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic [15:0]      txn_count
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SW = WIDTH / STAGES;
  localparam int unsigned XW = WIDTH + 1;

  // Each register level holds the operands entering its slice, the result bits
  // finished so far and the carry into its slice; the slice adder sits after it.
  logic [XW-1:0] opa_q [STAGES];
  logic [XW-1:0] opb_q [STAGES];
  logic [XW-1:0] res_q [STAGES];
  logic          cy_q  [STAGES];
  logic          v_q   [STAGES];
  logic          adv   [STAGES];
  logic [XW-1:0] res_d [STAGES];
  logic          cy_d  [STAGES];

  logic [XW-1:0] a_ext;
  logic [XW-1:0] b_mod;

  always_comb begin
    a_ext = SIGNED ? {a[WIDTH-1], a} : {1'b0, a};
    b_mod = (SIGNED ? {b[WIDTH-1], b} : {1'b0, b}) ^ {XW{op_sub}};
  end

  always_comb begin
    logic [XW-1:0] mask;
    logic [XW-1:0] t;
    logic [XW-1:0] t_hi;
    int unsigned   lo;
    int unsigned   hi_x;
    for (int unsigned i = 0; i < STAGES; i++) begin
      res_d[i] = '0;
      cy_d[i]  = 1'b0;
    end
    for (int unsigned i = 0; i < STAGES; i++) begin
      lo   = i * SW;
      hi_x = (i == STAGES - 1) ? XW : lo + SW;
      // Masked operands leave zeros below the slice, so the carry lands exactly at bit lo.
      mask = (XW'(1) << hi_x) - (XW'(1) << lo);
      t    = (opa_q[i] & mask) + (opb_q[i] & mask) + (XW'(cy_q[i]) << lo);
      t_hi = t >> hi_x;
      res_d[i] = (res_q[i] & ~mask) | (t & mask);
      cy_d[i]  = t_hi[0];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) adv[i] = 1'b0;
    adv[STAGES-1] = v_q[STAGES-1] & out_ready;
    for (int unsigned j = 1; j < STAGES; j++) begin
      adv[STAGES-1-j] = v_q[STAGES-1-j] & (!v_q[STAGES-j] | adv[STAGES-j]);
    end
  end

  always_comb begin
    in_ready  = !v_q[0] | adv[0];
    out_valid = v_q[STAGES-1];
    sum       = res_d[STAGES-1];
  end

`ifdef PIPE_ADDER_OVF_EN
  always_comb begin
    ovf = SIGNED ? (sum[WIDTH] ^ sum[WIDTH-1]) : sum[WIDTH];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        v_q[i]   <= 1'b0;
        opa_q[i] <= '0;
        opb_q[i] <= '0;
        res_q[i] <= '0;
        cy_q[i]  <= 1'b0;
      end
      txn_count <= '0;
    end else begin
      if (out_valid && out_ready) txn_count <= txn_count + 16'd1;
      if (in_ready) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          opa_q[0] <= a_ext;
          opb_q[0] <= b_mod;
          res_q[0] <= '0;
          cy_q[0]  <= op_sub;
        end
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (!v_q[i] || adv[i]) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) begin
            opa_q[i] <= opa_q[i-1];
            opb_q[i] <= opb_q[i-1];
            res_q[i] <= res_d[i-1];
            cy_q[i]  <= cy_d[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and randomized checks of pipe_adder: vector table, backpressure, reset flush, STAGES sweep.
`timescale 1ns/1ps
module tb_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, op_sub, out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, in_ready_s, out_valid_s;
  logic [8:0]  sum, sum_s;
  logic [15:0] txn_count, txn_count_s;
`ifdef PIPE_ADDER_OVF_EN
  logic        ovf, ovf_s;
`endif

  int checks = 0;
  int fails  = 0;

  pipe_adder #(.WIDTH(8), .STAGES(2), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .txn_count(txn_count)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipe_adder #(.WIDTH(8), .STAGES(2), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid_s), .out_ready(out_ready),
    .sum(sum_s), .txn_count(txn_count_s)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf_s)
`endif
  );

  logic        sw_iv  [3];
  logic        sw_ir  [3];
  logic        sw_ov  [3];
  logic        sw_or  [3];
  logic        sw_op  [3];
  logic [15:0] sw_a   [3];
  logic [15:0] sw_b   [3];
  logic [16:0] sw_sum [3];
  logic [15:0] sw_cnt [3];
`ifdef PIPE_ADDER_OVF_EN
  logic        sw_ovf [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    pipe_adder #(.WIDTH(16), .STAGES((g == 0) ? 1 : (g == 1) ? 2 : 4), .SIGNED(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[g]), .in_ready(sw_ir[g]),
      .a(sw_a[g]), .b(sw_b[g]), .op_sub(sw_op[g]), .out_valid(sw_ov[g]), .out_ready(sw_or[g]),
      .sum(sw_sum[g]), .txn_count(sw_cnt[g])
`ifdef PIPE_ADDER_OVF_EN
      , .ovf(sw_ovf[g])
`endif
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int stages_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [8:0] eu;
    logic [8:0] es;
    logic       ou;
    logic       os;
  } vec_t;

  vec_t vt [10];

  localparam int N = 1000;
  logic [16:0] exp_mem [3][N];
  int          acc_cyc [3][N];
  int          wr [3];
  int          rd [3];
  int          minlat [3];
  logic        taken [3];
  logic [16:0] ea, eb;
  int          cyc, lat, acc, got;

  initial begin
    vt[0] = '{8'd65,  8'd55,  1'b0, 9'h078, 9'h078, 1'b0, 1'b0};
    vt[1] = '{8'd200, 8'd100, 1'b0, 9'h12C, 9'h02C, 1'b1, 1'b0};
    vt[2] = '{8'd255, 8'd255, 1'b0, 9'h1FE, 9'h1FE, 1'b1, 1'b0};
    vt[3] = '{8'd50,  8'd60,  1'b1, 9'h1F6, 9'h1F6, 1'b1, 1'b0};
    vt[4] = '{8'd60,  8'd50,  1'b1, 9'h00A, 9'h00A, 1'b0, 1'b0};
    vt[5] = '{8'h80,  8'hFF,  1'b0, 9'h17F, 9'h17F, 1'b1, 1'b1};
    vt[6] = '{8'h00,  8'h00,  1'b1, 9'h000, 9'h000, 1'b0, 1'b0};
    vt[7] = '{8'h7F,  8'h01,  1'b0, 9'h080, 9'h080, 1'b0, 1'b1};
    vt[8] = '{8'h00,  8'h01,  1'b1, 9'h1FF, 9'h1FF, 1'b1, 1'b0};
    vt[9] = '{8'h80,  8'h01,  1'b1, 9'h07F, 9'h17F, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_sub = 1'b0; a = '0; b = '0;
    for (int k = 0; k < 3; k++) begin
      sw_iv[k] = 1'b0; sw_or[k] = 1'b0; sw_op[k] = 1'b0; sw_a[k] = '0; sw_b[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_txn_count", 32'(txn_count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
`ifdef PIPE_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 0);
`endif

    // Single beats with out_ready=1: result appears two edges after acceptance.
    for (int i = 0; i < 10; i++) begin
      a = vt[i].a; b = vt[i].b; op_sub = vt[i].sub; in_valid = 1'b1;
      #1;
      check("vec_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("vec_mid_valid", 32'(out_valid), 0);
      @(negedge clk);
      check("vec_out_valid", 32'(out_valid), 1);
      check("vec_sum_u", 32'(sum), 32'(vt[i].eu));
      check("vec_out_valid_s", 32'(out_valid_s), 1);
      check("vec_sum_s", 32'(sum_s), 32'(vt[i].es));
`ifdef PIPE_ADDER_OVF_EN
      check("vec_ovf_u", 32'(ovf), 32'(vt[i].ou));
      check("vec_ovf_s", 32'(ovf_s), 32'(vt[i].os));
`endif
      @(negedge clk);
      check("vec_drained", 32'(out_valid), 0);
      check("vec_txn_count", 32'(txn_count), 32'(i + 1));
      check("vec_txn_count_s", 32'(txn_count_s), 32'(i + 1));
    end

    // Backpressure: two beats fill the pipe, then in_ready must drop and sum hold.
    out_ready = 1'b0; op_sub = 1'b0; acc = 0; got = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; a = 8'(acc + 1); b = 8'(acc + 1);
      #1;
      if (c >= 2) check("bp_in_ready_low", 32'(in_ready), 0);
      if (in_ready) acc++;
      @(negedge clk);
      if (c >= 1) begin
        check("bp_stall_valid", 32'(out_valid), 1);
        check("bp_stall_sum", 32'(sum), 2);
      end
    end
    check("bp_accepted", 32'(acc), 2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (acc < 5) begin
        in_valid = 1'b1; a = 8'(acc + 1); b = 8'(acc + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        check("bp_order", 32'(sum), 32'(2 * (got + 1)));
        got++;
      end
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_outputs", 32'(got), 5);
    check("bp_txn_count", 32'(txn_count), 15);

    // Reset with a full pipe must flush everything.
    out_ready = 1'b0; in_valid = 1'b1; a = 8'd7; b = 8'd7;
    @(negedge clk);
    a = 8'd9; b = 8'd9;
    @(negedge clk);
    in_valid = 1'b0;
    check("flush_pre_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_txn_count", 32'(txn_count), 0);
    check("flush_in_ready", 32'(in_ready), 1);
    check("flush_sum", 32'(sum), 0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("flush_no_stale", 32'(out_valid), 0);
    end
    check("flush_txn_after", 32'(txn_count), 0);

    // Random sweep over STAGES=1,2,4 at WIDTH=16 with random backpressure.
    for (int k = 0; k < 3; k++) begin
      wr[k] = 0; rd[k] = 0; minlat[k] = 1000000; taken[k] = 1'b0;
    end
    cyc = 0;
    while ((rd[0] < N || rd[1] < N || rd[2] < N) && cyc < 20000) begin
      for (int k = 0; k < 3; k++) begin
        if (taken[k]) begin
          sw_iv[k] = 1'b0; taken[k] = 1'b0;
        end
        if (!sw_iv[k] && wr[k] < N && $urandom_range(0, 3) != 0) begin
          sw_iv[k] = 1'b1;
          sw_a[k]  = 16'($urandom);
          sw_b[k]  = 16'($urandom);
          sw_op[k] = 1'($urandom_range(0, 1));
        end
        sw_or[k] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        if (sw_ov[k] && sw_or[k]) begin
          if (rd[k] < wr[k]) begin
            check("sweep_sum", 32'(sw_sum[k]), 32'(exp_mem[k][rd[k]]));
            lat = cyc - acc_cyc[k][rd[k]];
            check("sweep_lat_ge", 32'(lat >= stages_of(k)), 1);
            if (lat < minlat[k]) minlat[k] = lat;
            rd[k]++;
          end else begin
            check("sweep_spurious", 32'(rd[k]), 32'(wr[k] + 1));
          end
        end
        if (sw_iv[k] && sw_ir[k]) begin
          ea = {1'b0, sw_a[k]};
          eb = {1'b0, sw_b[k]};
          exp_mem[k][wr[k]] = sw_op[k] ? (ea - eb) : (ea + eb);
          acc_cyc[k][wr[k]] = cyc;
          wr[k]++;
          taken[k] = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 3; k++) begin
      sw_iv[k] = 1'b0;
      check("sweep_done", 32'(rd[k]), N);
      check("sweep_txn_count", 32'(sw_cnt[k]), N);
      check("sweep_min_latency", 32'(minlat[k]), 32'(stages_of(k)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
